reg_file: RTL

//   32-entry general-purpose register file for the single-cycle MIPS datapath.

---
 rtl/reg_file_if.sv | 30 +++
 rtl/reg_file.sv | 62 ++++++
 2 files changed

// File: rtl/reg_file_if.sv
// Register-file access bundle between the datapath (master) and reg_file (slave).
// Carries two combinational read ports, one clocked write port and a debug read port.
//   rs_addr/rs_data : read port A (ALU in1)
//   rt_addr/rt_data : read port B (ALU in2 mux)
//   we/rd_addr/wd   : write port (RegWrite, muxed write index, write data)
//   dbg_addr/dbg_data : debug read port, never bypassed
interface reg_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              we;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output rs_addr, rt_addr, we, rd_addr, wd, dbg_addr,
    input  rs_data, rt_data, dbg_data
  );

  modport slave (
    input  rs_addr, rt_addr, we, rd_addr, wd, dbg_addr,
    output rs_data, rt_data, dbg_data
  );
endinterface

// File: rtl/reg_file.sv
// 32-entry MIPS general-purpose register file.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous reset, active-high; clears all entries, loads $sp with SP_INIT
//   rf  : reg_file_if.slave - rs/rt read ports, write port, debug read port
// Entry 0 is not stored and reads 0 on every port. Reads are combinational.
// Optional macro REGFILE_BYPASS_EN: forward wd to rs_data/rt_data when the
// write index matches the read index in the same cycle (dbg_data never bypassed).
module reg_file #(
  parameter int unsigned          DATA_W  = 32,
  parameter int unsigned          ADDR_W  = 5,
  parameter int unsigned          SP_IDX  = 29,
  parameter logic [DATA_W-1:0]    SP_INIT = 32'h0000_03FC
) (
  input  logic      clk,
  input  logic      rst,
  reg_file_if.slave rf
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Storage for entries 1..DEPTH-1; $zero has no flops.
  logic [DATA_W-1:0] mem_q [1:DEPTH-1];

  logic wr_hit;

  assign wr_hit = rf.we && (rf.rd_addr != '0);

  // Reset loads the power-on image; otherwise a single write per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem_q[ADDR_W'(i)] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (wr_hit) begin
      mem_q[rf.rd_addr] <= rf.wd;
    end
  end

  logic [DATA_W-1:0] rs_store;
  logic [DATA_W-1:0] rt_store;

  // Stored contents, with address 0 forced to zero.
  assign rs_store    = (rf.rs_addr  == '0) ? '0 : mem_q[rf.rs_addr];
  assign rt_store    = (rf.rt_addr  == '0) ? '0 : mem_q[rf.rt_addr];
  assign rf.dbg_data = (rf.dbg_addr == '0) ? '0 : mem_q[rf.dbg_addr];

`ifdef REGFILE_BYPASS_EN
  logic rs_byp;
  logic rt_byp;

  // Write-through forwarding; held off during reset so reads show the reset image.
  assign rs_byp     = !rst && wr_hit && (rf.rd_addr == rf.rs_addr);
  assign rt_byp     = !rst && wr_hit && (rf.rd_addr == rf.rt_addr);
  assign rf.rs_data = rs_byp ? rf.wd : rs_store;
  assign rf.rt_data = rt_byp ? rf.wd : rt_store;
`else
  assign rf.rs_data = rs_store;
  assign rf.rt_data = rt_store;
`endif

endmodule
